fp_mul_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshaking, round-to-nearest-even, special-value handling and exception flags. It is the next-generation multiply unit of the forensic speech datapath (filter banks, MFCC/energy stages). It replaces the single-cycle fp32-only multiplier and accepts a new operand pair every cycle when downstream is not stalling.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_mul_round.sv | 88 ++++++++
 rtl/fp_mul_pipe.sv | 133 +++++++++++++
 tb/tb_fp_mul_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_pkg : shared defaults, value classes and flag layout for the FP pipes    |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_e;

   // Canonical NaN is {CNAN_SIGN, all-ones exponent, fraction MSB set, rest clear}
   localparam logic CNAN_SIGN = 1'b0;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_mul_round : normalise, round-to-nearest-even, range check and pack       |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fp_mul_round
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                   sign_i,
   input  fp_class_e              cls_i,
   input  logic                   invalid_i,
   input  logic [EXP_W+1:0]       exp_i,
   input  logic [2*MAN_W+1:0]     prod_i,
   output logic [EXP_W+MAN_W:0]   p_o,
   output logic [3:0]             flags_o
);

   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam logic [EW2-1:0] EXP_ONE = {{(EW2-1){1'b0}}, 1'b1};
   localparam logic [EW2-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

   logic               msb;
   logic [MAN_W-1:0]   frac_pre;
   logic               guard;
   logic               sticky;
   logic               round_up;
   logic [MAN_W:0]     frac_rnd;
   logic [EW2-1:0]     exp_n;
   logic [EW2-1:0]     exp_r;
   logic               ovf;
   logic               unf;

   assign msb = prod_i[PW-1];

   // A product in [2,4) drops one more bit into the guard/sticky window
   always_comb begin
      if (msb) begin
         frac_pre = prod_i[PW-2:MAN_W+1];
         guard    = prod_i[MAN_W];
         sticky   = |prod_i[MAN_W-1:0];
         exp_n    = exp_i + EXP_ONE;
      end else begin
         frac_pre = prod_i[PW-3:MAN_W];
         guard    = prod_i[MAN_W-1];
         sticky   = |prod_i[MAN_W-2:0];
         exp_n    = exp_i;
      end
   end

   assign round_up = guard & (sticky | frac_pre[0]);
   assign frac_rnd = {1'b0, frac_pre} + {{MAN_W{1'b0}}, round_up};
   assign exp_r    = frac_rnd[MAN_W] ? exp_n + EXP_ONE : exp_n;
   assign ovf      = $signed(exp_r) >= $signed(EXP_MAX);
   assign unf      = exp_r[EW2-1] | (exp_r == '0);

   always_comb begin
      p_o     = '0;
      flags_o = '0;
      case (cls_i)
         CLS_NAN: begin
            p_o                   = {CNAN_SIGN, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_o[FLAG_INVALID] = invalid_i;
         end
         CLS_INF:  p_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         CLS_ZERO: p_o = {sign_i, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
         default: begin
            if (ovf) begin
               p_o                    = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_o[FLAG_OVERFLOW] = 1'b1;
               flags_o[FLAG_INEXACT]  = 1'b1;
            end else if (unf) begin
               p_o                     = {sign_i, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
               flags_o[FLAG_UNDERFLOW] = 1'b1;
               flags_o[FLAG_INEXACT]   = 1'b1;
            end else begin
               p_o                   = {sign_i, exp_r[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
               flags_o[FLAG_INEXACT] = guard | sticky;
            end
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_mul_pipe : 3-stage FP multiplier, valid/ready, RNE, flush-to-zero        |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_p,
   output logic [3:0]             out_flags
);

   localparam int EW2  = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int TOP  = EXP_W + MAN_W;
   localparam int BIAS = fp_bias(EXP_W);
   localparam logic [EW2-1:0] BIAS_E = BIAS[EW2-1:0];

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0) return CLS_ZERO;
      if (e != '1) return CLS_NORM;
      return (f == '0) ? CLS_INF : CLS_NAN;
   endfunction

   logic               en;
   fp_class_e          cls_a;
   fp_class_e          cls_b;
   fp_class_e          cls_d;
   logic               inv_d;
   logic               sign_d;
   logic [EW2-1:0]     exp_d;

   logic               v1_q, v2_q, v3_q;
   logic               s1_sign_q, s2_sign_q;
   fp_class_e          s1_cls_q, s2_cls_q;
   logic               s1_inv_q, s2_inv_q;
   logic [EW2-1:0]     s1_exp_q, s2_exp_q;
   logic [MAN_W:0]     s1_ma_q, s1_mb_q;
   logic [PW-1:0]      s2_prod_q;
   logic [TOP:0]       p_q;
   logic [3:0]         flags_q;

   logic [TOP:0]       round_p;
   logic [3:0]         round_flags;

   // The whole pipe advances together; a held output stalls every stage
   assign en       = ~v3_q | out_ready;
   assign in_ready = en;

   assign cls_a  = classify(in_a[TOP-1:MAN_W], in_a[MAN_W-1:0]);
   assign cls_b  = classify(in_b[TOP-1:MAN_W], in_b[MAN_W-1:0]);
   assign sign_d = in_a[TOP] ^ in_b[TOP];
   assign exp_d  = {2'b00, in_a[TOP-1:MAN_W]} + {2'b00, in_b[TOP-1:MAN_W]} - BIAS_E;

   always_comb begin
      inv_d = 1'b0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
         cls_d = CLS_NAN;
      end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                   (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
         cls_d = CLS_NAN;
         inv_d = 1'b1;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
         cls_d = CLS_INF;
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
         cls_d = CLS_ZERO;
      end else begin
         cls_d = CLS_NORM;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s1_sign_q <= sign_d;
         s1_cls_q  <= cls_d;
         s1_inv_q  <= inv_d;
         s1_exp_q  <= exp_d;
         s1_ma_q   <= {1'b1, in_a[MAN_W-1:0]};
         s1_mb_q   <= {1'b1, in_b[MAN_W-1:0]};
         s2_sign_q <= s1_sign_q;
         s2_cls_q  <= s1_cls_q;
         s2_inv_q  <= s1_inv_q;
         s2_exp_q  <= s1_exp_q;
         s2_prod_q <= {{(MAN_W+1){1'b0}}, s1_ma_q} * {{(MAN_W+1){1'b0}}, s1_mb_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         p_q     <= '0;
         flags_q <= '0;
      end else if (en) begin
         v1_q    <= in_valid;
         v2_q    <= v1_q;
         v3_q    <= v2_q;
         p_q     <= round_p;
         flags_q <= round_flags;
      end
   end

   fp_mul_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sign_i    (s2_sign_q),
      .cls_i     (s2_cls_q),
      .invalid_i (s2_inv_q),
      .exp_i     (s2_exp_q),
      .prod_i    (s2_prod_q),
      .p_o       (round_p),
      .flags_o   (round_flags)
   );

   assign out_valid = v3_q;
   assign out_p     = p_q;
   assign out_flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_mul_pipe : fp32 and fp16 instances against a value-level model        |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_fp_mul_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        v32_in, r32_in, v32_out, r32_out;
   logic [31:0] a32, b32, p32;
   logic [3:0]  f32;

   logic        v16_in, r16_in, v16_out, r16_out;
   logic [15:0] a16, b16, p16;
   logic [3:0]  f16;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(v32_in), .in_ready(r32_in), .in_a(a32), .in_b(b32),
      .out_valid(v32_out), .out_ready(r32_out), .out_p(p32), .out_flags(f32)
   );

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(v16_in), .in_ready(r16_in), .in_a(a16), .in_b(b16),
      .out_valid(v16_out), .out_ready(r16_out), .out_p(p16), .out_flags(f16)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] p; logic [3:0] f; } op_t;
   typedef struct { logic [31:0] p; logic [3:0] f; int cyc; } pend_t;
   op_t   ops[$];
   pend_t pend[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Exact value-level multiply: integer significand product, locate MSB, round by remainder
   function automatic logic [67:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input int ew, input int mw);
      longint unsigned emax, fmask, ea, eb, fa, fb, p, q, rem, half, s;
      longint e;
      int bias, n, shift;
      bit za, zb, ia, ib, na, nb;
      logic [63:0] res;
      logic [3:0]  fl;
      emax  = (64'd1 << ew) - 1;
      fmask = (64'd1 << mw) - 1;
      bias  = (1 << (ew - 1)) - 1;
      ea = (a >> mw) & emax;  fa = a & fmask;
      eb = (b >> mw) & emax;  fb = b & fmask;
      s  = ((a >> (ew + mw)) ^ (b >> (ew + mw))) & 64'd1;
      za = (ea == 0);  zb = (eb == 0);
      ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
      na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
      res = '0;
      fl  = '0;
      if (na || nb || (ia && zb) || (za && ib)) begin
         res   = (emax << mw) | (64'd1 << (mw - 1));
         fl[3] = (ia && zb) || (za && ib);
      end else if (ia || ib) begin
         res = (s << (ew + mw)) | (emax << mw);
      end else if (za || zb) begin
         res = s << (ew + mw);
      end else begin
         p = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
         n = 0;
         for (int i = 0; i < 64; i++) if (p[i]) n = i;
         e     = longint'(ea) + longint'(eb) - bias + (n - 2 * mw);
         shift = n - mw;
         q     = p >> shift;
         rem   = p & ((64'd1 << shift) - 1);
         half  = 64'd1 << (shift - 1);
         if (rem != 0) fl[0] = 1'b1;
         if (rem > half || (rem == half && q[0])) q++;
         if ((q >> (mw + 1)) != 0) begin
            q = q >> 1;
            e++;
         end
         if (e >= longint'(emax)) begin
            res = (s << (ew + mw)) | (emax << mw);
            fl  = 4'b0101;
         end else if (e <= 0) begin
            res = s << (ew + mw);
            fl  = 4'b0011;
         end else begin
            res = (s << (ew + mw)) | (64'(e) << mw) | (q & fmask);
         end
      end
      return {fl, res};
   endfunction

   function automatic logic [31:0] rnd32();
      logic [7:0] e;
      int k;
      k = $urandom_range(0, 15);
      if (k == 0)      e = 8'd0;
      else if (k == 1) e = 8'hFF;
      else if (k == 2) e = 8'($urandom_range(1, 20));
      else if (k == 3) e = 8'($urandom_range(235, 254));
      else             e = 8'($urandom_range(100, 154));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   function automatic logic [15:0] rnd16();
      logic [4:0] e;
      int k;
      k = $urandom_range(0, 9);
      if (k == 0)      e = 5'd0;
      else if (k == 1) e = 5'h1F;
      else             e = 5'($urandom_range(8, 22));
      return {1'($urandom_range(0, 1)), e, 10'($urandom)};
   endfunction

   task automatic push_dir(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [3:0] f);
      ops.push_back('{a, b, p, f});
   endtask

   task automatic push_rand();
      logic [31:0] a, b;
      logic [67:0] r;
      a = rnd32();
      b = rnd32();
      r = ref_mul({32'd0, a}, {32'd0, b}, 8, 23);
      ops.push_back('{a, b, r[31:0], r[67:64]});
   endtask

   // Called #1 after a rising edge; every cycle with out_valid must show the queue head
   task automatic run32(input bit rand_rdy, input bit lat_chk);
      int   guard;
      op_t  cur;
      guard = 0;
      cur   = '{32'd0, 32'd0, 32'd0, 4'd0};
      while ((ops.size() != 0 || pend.size() != 0) && guard < 3000) begin
         r32_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ops.size() != 0) begin
            cur    = ops[0];
            v32_in = 1'b1;
            a32    = cur.a;
            b32    = cur.b;
         end else begin
            v32_in = 1'b0;
         end
         #1;
         if (v32_out) begin
            if (pend.size() == 0) begin
               chk("spurious_valid", {63'd0, v32_out}, 64'd0);
            end else begin
               chk("p32", {32'd0, p32}, {32'd0, pend[0].p});
               chk("flags32", {60'd0, f32}, {60'd0, pend[0].f});
               if (r32_out) begin
                  if (lat_chk) chk("latency32", 64'(cyc - pend[0].cyc), 64'd3);
                  void'(pend.pop_front());
               end
            end
         end
         if (v32_in && r32_in) begin
            pend.push_back('{cur.p, cur.f, cyc});
            void'(ops.pop_front());
         end
         @(posedge clk);
         #1;
         guard++;
      end
      v32_in = 1'b0;
      chk("run32_drained", 64'(ops.size() + pend.size()), 64'd0);
   endtask

   task automatic one16(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] p, input logic [3:0] f);
      bit seen;
      seen    = 1'b0;
      r16_out = 1'b1;
      v16_in  = 1'b1;
      a16     = a;
      b16     = b;
      #1;
      chk("in_ready16", {63'd0, r16_in}, 64'd1);
      @(posedge clk);
      #1;
      v16_in = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (v16_out) begin
            seen = 1'b1;
            chk("p16", {48'd0, p16}, {48'd0, p});
            chk("flags16", {60'd0, f16}, {60'd0, f});
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!seen) chk("p16_timeout", {63'd0, v16_out}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb;
      logic [67:0] r;

      rst = 1'b1;
      v32_in = 1'b0; a32 = '0; b32 = '0; r32_out = 1'b1;
      v16_in = 1'b0; a16 = '0; b16 = '0; r16_out = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_out_valid", {63'd0, v32_out}, 64'd0);
      chk("reset_out_p", {32'd0, p32}, 64'd0);
      chk("reset_out_flags", {60'd0, f32}, 64'd0);
      chk("reset_in_ready", {63'd0, r32_in}, 64'd1);
      @(posedge clk);
      #1;

      // Directed fp32, back-to-back, no stall
      push_dir(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
      push_dir(32'h80000000, 32'h3F800000, 32'h80000000, 4'h0);
      push_dir(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1);
      push_dir(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1);
      push_dir(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8);
      push_dir(32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0);
      push_dir(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0);
      push_dir(32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5);
      push_dir(32'h00800000, 32'h3F000000, 32'h00000000, 4'h3);
      push_dir(32'h00000001, 32'h3F800000, 32'h00000000, 4'h0);
      run32(1'b0, 1'b1);

      // Random stream with pseudo-random backpressure
      for (int i = 0; i < 30; i++) push_rand();
      run32(1'b1, 1'b0);

      // Reset with three operands in flight
      r32_out = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v32_in = 1'b1;
         a32    = rnd32();
         b32    = rnd32();
         @(posedge clk);
         #1;
      end
      v32_in = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_out_p", {32'd0, p32}, 64'd0);
      chk("midrst_out_flags", {60'd0, f32}, 64'd0);
      chk("midrst_in_ready", {63'd0, r32_in}, 64'd1);
      for (int i = 0; i < 6; i++) begin
         chk("midrst_no_valid", {63'd0, v32_out}, 64'd0);
         @(posedge clk);
         #1;
      end

      push_dir(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
      push_dir(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1);
      run32(1'b0, 1'b1);

      // fp16 directed cases
      one16(16'h3E00, 16'h4000, 16'h4200, 4'h0);
      one16(16'h8000, 16'h3C00, 16'h8000, 4'h0);
      one16(16'h3C03, 16'h3E00, 16'h3E04, 4'h1);
      one16(16'h3C01, 16'h3E00, 16'h3E02, 4'h1);
      one16(16'h7C00, 16'h0000, 16'h7E00, 4'h8);
      one16(16'hFC00, 16'h4000, 16'hFC00, 4'h0);
      one16(16'h7E01, 16'h3C00, 16'h7E00, 4'h0);
      one16(16'h7800, 16'h4000, 16'h7C00, 4'h5);
      one16(16'h0400, 16'h3800, 16'h0000, 4'h3);
      one16(16'h0001, 16'h3C00, 16'h0000, 4'h0);

      // fp16 random against the model
      for (int i = 0; i < 10; i++) begin
         ra = rnd16();
         rb = rnd16();
         r  = ref_mul({48'd0, ra}, {48'd0, rb}, 5, 10);
         one16(ra, rb, r[15:0], r[67:64]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
